// File: rtl/mac_array_isoschedule.sv
// Multi-lane multiply-accumulate engine: product stage, accumulate stage, valid/ready result.
// Define MAC_SATURATE_EN for saturating per-lane accumulation instead of wrap-around.
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module mac_array_isoschedule #(
  parameter int LANES = 4,
  parameter int IN_W  = `INPUT_WIDTH,
  parameter int WT_W  = `WEIGHT_WIDTH,
  parameter int ACC_W = `ACC_WIDTH,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_signed,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_act,
  input  logic [LANES*WT_W-1:0]  in_wgt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_acc,
  output logic                   busy
);
  localparam int PW = IN_W + WT_W;
  localparam logic [ACC_W-1:0] EXT_M = {ACC_W{1'b1}} << PW;

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("ACC_W must be at least IN_W+WT_W");
  end

  logic             adv, fire, first, last, sgn_eff;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_eff;
  logic             sgn_q;

  logic [LANES*PW-1:0] p_q, p_d;
  logic                p_valid_q, p_first_q, p_last_q, p_sgn_q;
  logic [PW-1:0]       ax, wx;

  logic [LANES*ACC_W-1:0] acc_q, acc_nx, out_acc_q;
  logic [ACC_W-1:0]       pe, base;
  logic                   out_valid_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign fire      = in_valid && adv;
  assign first     = (cnt_q == '0);
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign busy      = (cnt_q != '0) || p_valid_q;

  // Group framing: pick live config on the first beat, latched config afterwards.
  always_comb begin
    len_eff = len_q;
    sgn_eff = sgn_q;
    if (first) begin
      len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      sgn_eff = cfg_signed;
    end
    last  = (cnt_q == len_eff - LEN_W'(1));
    cnt_d = last ? '0 : cnt_q + LEN_W'(1);
  end

  // Beat counter and per-group configuration latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
      sgn_q <= 1'b0;
    end else if (fire) begin
      cnt_q <= cnt_d;
      if (first) begin
        len_q <= len_eff;
        sgn_q <= sgn_eff;
      end
    end
  end

  // Per-lane products; one multiplier handles both modes via operand extension.
  always_comb begin
    p_d = '0;
    ax  = '0;
    wx  = '0;
    for (int i = 0; i < LANES; i++) begin
      ax = {{WT_W{sgn_eff & in_act[i*IN_W+IN_W-1]}}, in_act[i*IN_W +: IN_W]};
      wx = {{IN_W{sgn_eff & in_wgt[i*WT_W+WT_W-1]}}, in_wgt[i*WT_W +: WT_W]};
      p_d[i*PW +: PW] = ax * wx;
    end
  end

  // Stage 1: product register with group markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_sgn_q   <= 1'b0;
    end else if (adv) begin
      p_valid_q <= fire;
      if (fire) begin
        p_q       <= p_d;
        p_first_q <= first;
        p_last_q  <= last;
        p_sgn_q   <= sgn_eff;
      end
    end
  end

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [LANES-1:0] sat_q, sat_d;
  logic [ACC_W:0]   s;
  logic             hold, ovf;

  // Saturating accumulate; once clamped a lane holds its value until the next group.
  always_comb begin
    acc_nx = '0;
    sat_d  = sat_q;
    pe     = '0;
    base   = '0;
    s      = '0;
    hold   = 1'b0;
    ovf    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      pe   = ACC_W'(p_q[i*PW +: PW]) |
             ((p_sgn_q && p_q[i*PW+PW-1]) ? EXT_M : '0);
      base = p_first_q ? '0 : acc_q[i*ACC_W +: ACC_W];
      hold = !p_first_q && sat_q[i];
      if (p_sgn_q) s = {base[ACC_W-1], base} + {pe[ACC_W-1], pe};
      else         s = {1'b0, base} + {1'b0, pe};
      ovf  = p_sgn_q ? (s[ACC_W] ^ s[ACC_W-1]) : s[ACC_W];
      if (hold)
        acc_nx[i*ACC_W +: ACC_W] = base;
      else if (ovf)
        acc_nx[i*ACC_W +: ACC_W] = p_sgn_q ? (s[ACC_W] ? SMIN : SMAX) : '1;
      else
        acc_nx[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
      sat_d[i] = hold | ovf;
    end
  end

  // Sticky saturation flags follow the accumulator enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sat_q <= '0;
    else if (adv && p_valid_q) sat_q <= sat_d;
  end
`else
  // Wrapping accumulate of the extended products.
  always_comb begin
    acc_nx = '0;
    pe     = '0;
    base   = '0;
    for (int i = 0; i < LANES; i++) begin
      pe   = ACC_W'(p_q[i*PW +: PW]) |
             ((p_sgn_q && p_q[i*PW+PW-1]) ? EXT_M : '0);
      base = p_first_q ? '0 : acc_q[i*ACC_W +: ACC_W];
      acc_nx[i*ACC_W +: ACC_W] = base + pe;
    end
  end
`endif

  // Stage 2: accumulator and held output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_acc_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (p_valid_q) begin
        if (p_last_q) begin
          out_acc_q   <= acc_nx;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_array_isoschedule.sv
// Directed bench for mac_array_isoschedule: vector table plus stall,
// overflow and mid-group reset sequences.
module tb_mac_array_isoschedule;
  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int WT_W  = 8;
  localparam int ACC_W = 17;
  localparam int LEN_W = 8;
  localparam int BW    = LANES * ACC_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_signed;
  logic [LEN_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_act, in_wgt;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_acc;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        sgn;
    logic [7:0]  len;
    logic [31:0] act;
    logic [31:0] wgt;
    int          e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[5];

  mac_array_isoschedule #(
    .LANES(LANES), .IN_W(IN_W), .WT_W(WT_W),
    .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_signed(cfg_signed), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pk(int e0, int e1, int e2, int e3);
    logic [BW-1:0] r;
    r[0*ACC_W +: ACC_W] = e0[ACC_W-1:0];
    r[1*ACC_W +: ACC_W] = e1[ACC_W-1:0];
    r[2*ACC_W +: ACC_W] = e2[ACC_W-1:0];
    r[3*ACC_W +: ACC_W] = e3[ACC_W-1:0];
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic send(logic s, logic [7:0] l, logic [31:0] a, logic [31:0] w);
    @(negedge clk);
    cfg_signed = s;
    cfg_len    = l;
    in_act     = a;
    in_wgt     = w;
    in_valid   = 1'b1;
  endtask

  // Waits for a result after the last beat; result is due on the 2nd negedge.
  task automatic wait_out(string nm, logic [BW-1:0] exp);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) got = 1'b1;
    end
    chk({nm, "_lat"}, got ? n : 0, 2);
    chk({nm, "_acc"}, out_acc, exp);
  endtask

  logic [BW-1:0] held;
  logic [BW-1:0] ovf_exp;
  bit            seen;

  initial begin
    tbl[0] = '{1'b0, 8'd0, {8'd4, 8'd3, 8'd2, 8'd1},
               {8'd8, 8'd7, 8'd6, 8'd5}, 5, 12, 21, 32};
    tbl[1] = '{1'b1, 8'd0, {8'h02, 8'h7F, 8'hFF, 8'h80},
               {8'hFD, 8'h7F, 8'hFF, 8'h7F}, -16256, 1, 16129, -6};
    tbl[2] = '{1'b0, 8'd1, {8'd128, 8'd0, 8'd255, 8'd255},
               {8'd2, 8'd200, 8'd1, 8'd255}, 65025, 255, 0, 256};
    tbl[3] = '{1'b0, 8'd0, {8'd9, 8'd3, 8'd16, 8'd128},
               {8'd9, 8'd0, 8'd16, 8'd128}, 16384, 256, 0, 81};
    tbl[4] = '{1'b1, 8'd1, {8'h64, 8'hF9, 8'h05, 8'hFF},
               {8'h9C, 8'hF9, 8'hFB, 8'h01}, -1, -25, 49, -10000};

    rst        = 1'b1;
    cfg_signed = 1'b0;
    cfg_len    = 8'd1;
    in_act     = 32'h0101_0101;
    in_wgt     = 32'h0101_0101;
    in_valid   = 1'b1;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("rst_ignore_busy", busy, 0);
    chk("rst_ignore_valid", out_valid, 0);

    // Unsigned group of three identical beats.
    repeat (3) send(1'b0, 8'd3, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    wait_out("len3", pk(15, 36, 63, 96));
    chk("len3_busy", busy, 0);
    @(negedge clk);
    chk("len3_once", out_valid, 0);

    // Signed group of two beats on lane 0.
    send(1'b1, 8'd2, 32'h0000_0080, 32'h0000_007F);
    send(1'b1, 8'd2, 32'h0000_00FF, 32'h0000_00FF);
    wait_out("signed", pk(-16255, 0, 0, 0));

    // Single-beat groups, continuous valid: one result per cycle.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("tbl%0d_valid", k - 2), out_valid, 1);
        chk($sformatf("tbl%0d_acc", k - 2), out_acc,
            pk(tbl[k-2].e0, tbl[k-2].e1, tbl[k-2].e2, tbl[k-2].e3));
      end
      if (k < 5) begin
        cfg_signed = tbl[k].sgn;
        cfg_len    = tbl[k].len;
        in_act     = tbl[k].act;
        in_wgt     = tbl[k].wgt;
        in_valid   = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: result A held while group B waits behind it.
    send(1'b0, 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0101_0101);
    out_ready = 1'b0;
    send(1'b0, 8'd2, 32'h0202_0202, 32'h0303_0303);
    held = pk(1, 2, 3, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
      chk($sformatf("stall%0d_valid", k), out_valid, 1);
      chk($sformatf("stall%0d_acc", k), out_acc, held);
    end
    out_ready = 1'b1;
    wait_out("stall_next", pk(12, 12, 12, 12));
    @(negedge clk);
    chk("stall_no_dup", out_valid, 0);

    // Overflow of every lane over a four-beat group.
    repeat (4) send(1'b0, 8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MAC_SATURATE_EN
    ovf_exp = pk(32'h1FFFF, 32'h1FFFF, 32'h1FFFF, 32'h1FFFF);
`else
    ovf_exp = pk(32'h1F804, 32'h1F804, 32'h1F804, 32'h1F804);
`endif
    wait_out("overflow", ovf_exp);

    // Reset during the second beat of a four-beat group.
    send(1'b0, 8'd4, 32'h0505_0505, 32'h0505_0505);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_out", seen, 0);
    repeat (2) send(1'b0, 8'd2, 32'h0101_0101, 32'h0303_0303);
    wait_out("after_rst", pk(6, 6, 6, 6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
